// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a 2-bit
// per-register pending-write scoreboard. Optional macro: REGFILE_SB_BYPASS_EN (write-to-read bypass).
module regfile_sb #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_rd,
    output logic          err
);

    logic [DW-1:0]   mem_q [NREG];
    logic [1:0]      cnt_q [NREG];
    logic [1:0]      cnt_d [NREG];
    logic            err_q;
    logic            err_d;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic            wr_ok;

    // Writes to the hard-wired zero register are dropped entirely.
    assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            if (!((ZERO_REG != 0) && (r == 0))) begin
                inc[r] = iss_en && (iss_rd == AW'(r));
                dec[r] = we && (wa == AW'(r));
            end
        end
    end

    // Counters saturate at 3 and 0; hitting either bound sets the sticky error.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc[r] && !dec[r]) begin
                if (cnt_q[r] == 2'd3) err_d = 1'b1;
                else                  cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec[r] && !inc[r]) begin
                if (cnt_q[r] == 2'd0) err_d = 1'b1;
                else                  cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
            if (wr_ok) mem_q[wa] <= wd;
        end
    end

    function automatic logic [DW-1:0] zero_mask(input logic [AW-1:0] ra,
                                                input logic [DW-1:0] stored);
        logic [DW-1:0] v;
        v = stored;
        if ((ZERO_REG != 0) && (ra == '0)) v = '0;
        return v;
    endfunction

`ifdef REGFILE_SB_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = wr_ok && (wa == ra1);
    assign hit2 = wr_ok && (wa == ra2);

    // A writeback landing this cycle satisfies one pending write early.
    function automatic logic busy_byp(input logic [1:0] cnt, input logic hit);
        return (cnt > 2'd1) || ((cnt == 2'd1) && !hit);
    endfunction

    assign rd1   = hit1 ? wd : zero_mask(ra1, mem_q[ra1]);
    assign rd2   = hit2 ? wd : zero_mask(ra2, mem_q[ra2]);
    assign busy1 = busy_byp(cnt_q[ra1], hit1);
    assign busy2 = busy_byp(cnt_q[ra2], hit2);
`else
    assign rd1   = zero_mask(ra1, mem_q[ra1]);
    assign rd2   = zero_mask(ra2, mem_q[ra2]);
    assign busy1 = (cnt_q[ra1] != 2'd0);
    assign busy2 = (cnt_q[ra2] != 2'd0);
`endif

    assign err = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters); bypass
// expectations follow REGFILE_SB_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra1, ra2, wa, iss_rd;
    logic [DW-1:0] rd1, rd2, wd;
    logic          busy1, busy2, we, iss_en, err;

    int n_vec = 0;
    int n_err = 0;

    regfile_sb dut (
        .clk    (clk),
        .rst    (rst),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .busy1  (busy1),
        .busy2  (busy2),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .iss_en (iss_en),
        .iss_rd (iss_rd),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        we = 1'b0; iss_en = 1'b0; rst = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] r);
        idle(); iss_en = 1'b1; iss_rd = r; tick();
    endtask

    task automatic wback(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle(); we = 1'b1; wa = a; wd = d; tick();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; iss_en = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; iss_rd = '0;
        tick(); tick();
        idle();
        ra1 = 5'd5; ra2 = 5'd31;
        settle();
        check("rst_rd1",   rd1,   32'h0);
        check("rst_rd2",   rd2,   32'h0);
        check("rst_busy1", busy1, 32'h0);
        check("rst_busy2", busy2, 32'h0);
        check("rst_err",   err,   32'h0);

        // write and read back (issued first so the writeback is legal)
        issue(5'd7);
        wback(5'd7, 32'hDEADBEEF);
        idle(); ra1 = 5'd7; settle();
        check("wr_rd1",   rd1,   32'hDEADBEEF);
        check("wr_busy1", busy1, 32'h0);
        check("wr_err",   err,   32'h0);

        wback(5'd0, 32'h1234);
        idle(); ra2 = 5'd0; settle();
        check("zero_rd2",   rd2,   32'h0);
        check("zero_busy2", busy2, 32'h0);
        check("zero_err",   err,   32'h0);

        // scoreboard on r3
        ra1 = 5'd3;
        issue(5'd3);
        issue(5'd3);
        idle(); settle();
        check("sb_busy_cnt2", busy1, 32'h1);
        wback(5'd3, 32'h33);
        idle(); settle();
        check("sb_busy_cnt1", busy1, 32'h1);
        check("sb_rd_33",     rd1,   32'h33);
        idle(); iss_en = 1'b1; iss_rd = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h44; tick();
        idle(); settle();
        check("sb_same_busy", busy1, 32'h1);
        check("sb_same_rd",   rd1,   32'h44);
        wback(5'd3, 32'h55);
        idle(); settle();
        check("sb_busy_cnt0", busy1, 32'h0);
        check("sb_rd_55",     rd1,   32'h55);
        check("sb_err",       err,   32'h0);

        // same-cycle write and read of r10 with one pending write
        issue(5'd10);
        idle(); ra1 = 5'd10; we = 1'b1; wa = 5'd10; wd = 32'hA5A5A5A5; settle();
`ifdef REGFILE_SB_BYPASS_EN
        check("byp_rd1",   rd1,   32'hA5A5A5A5);
        check("byp_busy1", busy1, 32'h0);
`else
        check("byp_rd1",   rd1,   32'h0);
        check("byp_busy1", busy1, 32'h1);
`endif
        tick();
        idle(); settle();
        check("byp_next_rd1",   rd1,   32'hA5A5A5A5);
        check("byp_next_busy1", busy1, 32'h0);
        check("byp_err",        err,   32'h0);

        // overflow on r9: saturates at 3
        ra2 = 5'd9;
        issue(5'd9); issue(5'd9); issue(5'd9);
        idle(); settle();
        check("ovf_err_before", err, 32'h0);
        issue(5'd9);
        idle(); settle();
        check("ovf_err",   err,   32'h1);
        check("ovf_busy2", busy2, 32'h1);
        wback(5'd9, 32'h9); wback(5'd9, 32'h9);
        idle(); settle();
        check("ovf_cnt1_busy", busy2, 32'h1);
        wback(5'd9, 32'h99);
        idle(); settle();
        check("ovf_cnt0_busy", busy2, 32'h0);
        check("ovf_rd2",       rd2,   32'h99);

        // reset, then underflow on r4
        idle(); rst = 1'b1; tick();
        idle(); ra1 = 5'd10; settle();
        check("rst2_err",   err,   32'h0);
        check("rst2_busy2", busy2, 32'h0);
        check("rst2_rd1",   rd1,   32'h0);
        wback(5'd4, 32'h4444);
        idle(); ra1 = 5'd4; settle();
        check("unf_err",   err,   32'h1);
        check("unf_rd1",   rd1,   32'h4444);
        check("unf_busy1", busy1, 32'h0);

        // reset mid-operation with write and issue in the same cycle
        ra2 = 5'd2;
        issue(5'd2); issue(5'd2);
        idle(); settle();
        check("mid_busy2_pre", busy2, 32'h1);
        rst = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'hBAD; iss_en = 1'b1; iss_rd = 5'd2; tick();
        idle(); settle();
        check("mid_busy2", busy2, 32'h0);
        check("mid_rd2",   rd2,   32'h0);
        check("mid_rd1",   rd1,   32'h0);
        check("mid_err",   err,   32'h0);
        wback(5'd2, 32'h22);
        idle(); settle();
        check("mid_cnt0_unf", err, 32'h1);
        check("mid_rd2_new",  rd2, 32'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
